reg_file: RTL and testbench
===========================

Name: reg_file

Overview:
- Multi-ported register file built from the catalog's 32-bit registers, each register being a bank of positive-edge D flip-flops.
- Sits between the write-back stage and operand fetch of the single-cycle/pipelined datapath.
- Provides two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero, and a same-cycle write is bypassed to the read ports.

Parameters:
- WIDTH, 32: data width of each register in bits.
- DEPTH, 32: number of registers.
- ADDR_W, 5: address width; must satisfy 2**ADDR_W >= DEPTH.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all registers immediately.
- we  input  1  write enable, sampled on rising clk.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH  write data.
- raddr1  input  ADDR_W  read address, port 1.
- raddr2  input  ADDR_W  read address, port 2.
- rdata1  output  WIDTH  read data, port 1.
- rdata2  output  WIDTH  read data, port 2.
- wr_count  output  8  count of committed writes to non-zero registers, saturating.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - All DEPTH registers go to 0; wr_count goes to 0.
  - rdata1/rdata2 read 0 while reset is held.
  - Writes are ignored while reset=0.
  - Deassertion takes effect at the next rising clk.
- Write:
  - On rising clk with reset=1, we=1, waddr!=0 and waddr<DEPTH: reg[waddr] <= wdata and wr_count increments by 1.
  - wr_count saturates at 255 (no wrap).
- Ignored writes:
  - waddr==0: no state change, no count.
  - waddr>=DEPTH (when DEPTH<2**ADDR_W): no state change, no count.
- Register 0: always reads 0 regardless of any write history.
- Read:
  - Combinational, zero latency: rdataN = reg[raddrN].
  - raddrN>=DEPTH reads 0.
- Bypass (write-through):
  - Condition: we=1 and waddr==raddrN and raddrN!=0 and raddrN<DEPTH, with reset=1.
  - Then rdataN = wdata in the same cycle, before the edge.
  - After the edge, the stored value equals the same wdata, so the read value is stable across the edge.
- Simultaneous events:
  - Both read ports may address the same register as each other and as the write port; both return the bypassed wdata.
  - Reads of other registers are unaffected by the write.
- Reset mid-operation: an asynchronous assert during a cycle with we=1 discards the pending write; the register reads 0 afterwards.
- Structure and widths:
  - One register per index (index 0 constant zero), a write decoder, and two DEPTH:1 read multiplexers.
  - No truncation of data; address comparisons use the full ADDR_W bits.

Test Plan:
1. Assert reset=0 mid-simulation after loading r5=32'hDEAD_BEEF → rdata1 (raddr1=5) reads 0 immediately, without a clk edge; wr_count=0.
2. reset=1; write we=1, waddr=3, wdata=32'h1234_5678 on one edge; next cycle raddr1=3, raddr2=3 → both read 32'h1234_5678; wr_count=1.
3. we=1, waddr=0, wdata=32'hFFFF_FFFF; then raddr1=0 → rdata1=0; wr_count unchanged.
4. Bypass: r7 holds 32'hAAAA_AAAA; in one cycle set we=1, waddr=7, wdata=32'h5555_5555, raddr1=7, raddr2=8 (r8=32'h0000_0008):
   - Before the edge: rdata1=32'h5555_5555, rdata2=32'h0000_0008.
   - After the edge: rdata1 still 32'h5555_5555.
5. 300 consecutive writes to address 1 with incrementing data → wr_count stops at 255; r1 holds the last data written (value 299 if starting at 0).
6. Write all registers 1..31 with data=index*32'h0101_0101; sweep raddr1/raddr2 over 0..31 → each reads its pattern and r0 reads 0; then pulse reset low for half a cycle → all read 0.

Source files
------------

// File: rtl/reg_file.sv
// rtl/reg_file.sv - two-read, one-write register file with zero register and write bypass
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [WIDTH-1:0]  rdata1,
  output logic [WIDTH-1:0]  rdata2,
  output logic [7:0]        wr_count
);

  // DEPTH widened by one bit so the range check works even when DEPTH == 2**ADDR_W
  localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W + 1)'(DEPTH);
  localparam logic [7:0]      COUNT_MAX = 8'd255;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] wr_sel;
  logic             waddr_ok;
  logic             wr_commit;
  logic             raddr1_ok;
  logic             raddr2_ok;
  logic             bypass1;
  logic             bypass2;
  logic [WIDTH-1:0] mux1;
  logic [WIDTH-1:0] mux2;

  // A write only lands on a real, non-zero register
  assign waddr_ok  = (waddr != '0) && ({1'b0, waddr} < DEPTH_EXT);
  assign wr_commit = we && waddr_ok;

  assign raddr1_ok = (raddr1 != '0) && ({1'b0, raddr1} < DEPTH_EXT);
  assign raddr2_ok = (raddr2 != '0) && ({1'b0, raddr2} < DEPTH_EXT);

  // Write decoder: one-hot select over registers 1..DEPTH-1, bit 0 never set
  always_comb begin
    wr_sel = '0;
    for (int i = 1; i < DEPTH; i++) begin
      wr_sel[i] = wr_commit && (waddr == ADDR_W'(i));
    end
  end

  // Register storage; index 0 is only ever loaded by reset so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 1; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          mem[i] <= wdata;
        end
      end
    end
  end

  // Committed-write counter, sticks at its maximum instead of wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_count <= '0;
    end else if (wr_commit && (wr_count != COUNT_MAX)) begin
      wr_count <= wr_count + 8'd1;
    end
  end

  // Read port 1 multiplexer; register 0 and out-of-range addresses fall through to zero
  always_comb begin
    mux1 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (raddr1 == ADDR_W'(i)) begin
        mux1 = mem[i];
      end
    end
  end

  // Read port 2 multiplexer, identical decode to port 1
  always_comb begin
    mux2 = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (raddr2 == ADDR_W'(i)) begin
        mux2 = mem[i];
      end
    end
  end

  // Same-cycle write forwarding so the consumer sees the value before it is stored
  assign bypass1 = reset && we && waddr_ok && raddr1_ok && (raddr1 == waddr);
  assign bypass2 = reset && we && waddr_ok && raddr2_ok && (raddr2 == waddr);

  // Hold reads at zero while reset is asserted, otherwise forward or read storage
  assign rdata1 = !reset ? '0 : (bypass1 ? wdata : mux1);
  assign rdata2 = !reset ? '0 : (bypass2 ? wdata : mux2);

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - self-checking bench for reg_file against a queue-free array model
module tb_reg_file;

  logic        clk;
  logic        reset;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [7:0]  wr_count;

  int vectors;
  int miscompares;

  // Reference model: architectural register contents and committed-write tally
  logic [31:0] model [32];
  int          model_cnt;

  reg_file #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    model_cnt = 0;
  endfunction

  // Expected read value from the architectural rules, seen before the clock edge
  function automatic logic [31:0] exp_rd(input int a);
    if (!reset) return 32'h0;
    if (a == 0 || a >= 32) return 32'h0;
    if (we && int'(waddr) == a) return wdata;
    return model[a];
  endfunction

  // Advance one rising edge, applying the write rules to the model
  task automatic step();
    @(posedge clk);
    if (reset && we && waddr != 5'd0) begin
      model[waddr] = wdata;
      if (model_cnt < 255) model_cnt++;
    end
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    we = 1'b1; waddr = a; wdata = d;
    step();
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr1 = 5'd5; raddr2 = 5'd31;
    model_clear();
    #1;
    vectors++;
    if (wr_count !== 8'd0) begin
      miscompares++; $display("FAIL reset_count actual=%0d required=0", wr_count);
    end
    vectors++;
    if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
      miscompares++; $display("FAIL reset_read actual=%h/%h required=0/0", rdata1, rdata2);
    end
    @(negedge clk);
    reset = 1'b1;
    write_reg(5'd5, 32'hDEAD_BEEF);
    raddr1 = 5'd5;
    #1;
    vectors++;
    if (rdata1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL load_r5 actual=%h required=deadbeef", rdata1);
    end
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || wr_count !== 8'd0) begin
      miscompares++; $display("FAIL async_reset actual=%h cnt=%0d required=0 cnt=0", rdata1, wr_count);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_write_read();
    write_reg(5'd3, 32'h1234_5678);
    raddr1 = 5'd3; raddr2 = 5'd3;
    #1;
    vectors++;
    if (rdata1 !== 32'h1234_5678 || rdata2 !== 32'h1234_5678) begin
      miscompares++; $display("FAIL write_read actual=%h/%h required=12345678/12345678", rdata1, rdata2);
    end
    vectors++;
    if (wr_count !== 8'd1) begin
      miscompares++; $display("FAIL write_count actual=%0d required=1", wr_count);
    end
  endtask

  task automatic test_zero_write();
    write_reg(5'd0, 32'hFFFF_FFFF);
    raddr1 = 5'd0;
    #1;
    vectors++;
    if (rdata1 !== 32'h0) begin
      miscompares++; $display("FAIL r0_read actual=%h required=0", rdata1);
    end
    vectors++;
    if (wr_count !== 8'd1) begin
      miscompares++; $display("FAIL r0_count actual=%0d required=1", wr_count);
    end
  endtask

  task automatic test_bypass();
    write_reg(5'd7, 32'hAAAA_AAAA);
    write_reg(5'd8, 32'h0000_0008);
    @(negedge clk);
    we = 1'b1; waddr = 5'd7; wdata = 32'h5555_5555; raddr1 = 5'd7; raddr2 = 5'd8;
    #1;
    vectors++;
    if (rdata1 !== 32'h5555_5555 || rdata2 !== 32'h0000_0008) begin
      miscompares++; $display("FAIL bypass_pre actual=%h/%h required=55555555/00000008", rdata1, rdata2);
    end
    step();
    vectors++;
    if (rdata1 !== 32'h5555_5555) begin
      miscompares++; $display("FAIL bypass_post actual=%h required=55555555", rdata1);
    end
    we = 1'b0;
    #1;
    vectors++;
    if (rdata1 !== 32'h5555_5555) begin
      miscompares++; $display("FAIL bypass_stored actual=%h required=55555555", rdata1);
    end
    @(negedge clk);
    we = 1'b1; waddr = 5'd8; wdata = 32'hC0DE_0001; raddr1 = 5'd8; raddr2 = 5'd8;
    #1;
    vectors++;
    if (rdata1 !== 32'hC0DE_0001 || rdata2 !== 32'hC0DE_0001) begin
      miscompares++; $display("FAIL bypass_both actual=%h/%h required=c0de0001/c0de0001", rdata1, rdata2);
    end
    step();
    we = 1'b0;
  endtask

  task automatic test_saturation();
    @(negedge clk);
    for (int i = 0; i < 300; i++) begin
      we = 1'b1; waddr = 5'd1; wdata = i;
      step();
    end
    we = 1'b0; raddr1 = 5'd1;
    #1;
    vectors++;
    if (wr_count !== 8'd255) begin
      miscompares++; $display("FAIL saturate actual=%0d required=255", wr_count);
    end
    vectors++;
    if (rdata1 !== 32'd299) begin
      miscompares++; $display("FAIL sat_last_data actual=%0d required=299", rdata1);
    end
  endtask

  task automatic test_sweep();
    int bad;
    for (int i = 1; i < 32; i++) write_reg(5'(i), i * 32'h0101_0101);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      vectors++;
      if (rdata1 !== i * 32'h0101_0101 || rdata2 !== (31 - i) * 32'h0101_0101) begin
        miscompares++;
        $display("FAIL sweep idx=%0d actual=%h/%h required=%h/%h", i, rdata1, rdata2,
                 i * 32'h0101_0101, (31 - i) * 32'h0101_0101);
      end
    end
    @(posedge clk);
    #2;
    reset = 1'b0;
    model_clear();
    #5;
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(i);
      #1;
      if (rdata1 !== 32'h0 || rdata2 !== 32'h0) bad++;
    end
    vectors++;
    if (bad != 0 || wr_count !== 8'd0) begin
      miscompares++; $display("FAIL sweep_reset nonzero_reads=%0d cnt=%0d required=0 cnt=0", bad, wr_count);
    end
  endtask

  task automatic test_mid_write_reset();
    write_reg(5'd9, 32'h0BAD_F00D);
    @(negedge clk);
    we = 1'b1; waddr = 5'd9; wdata = $urandom; raddr1 = 5'd9;
    #2;
    reset = 1'b0;
    model_clear();
    step();
    @(negedge clk);
    we = 1'b0;
    reset = 1'b1;
    #1;
    vectors++;
    if (rdata1 !== 32'h0 || wr_count !== 8'd0) begin
      miscompares++; $display("FAIL mid_write_reset actual=%h cnt=%0d required=0 cnt=0", rdata1, wr_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      we     = ($urandom_range(0, 3) != 0);
      waddr  = 5'($urandom_range(0, 31));
      wdata  = $urandom;
      raddr1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr2 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      #1;
      e1 = exp_rd(int'(raddr1));
      e2 = exp_rd(int'(raddr2));
      vectors++;
      if (rdata1 !== e1 || rdata2 !== e2) begin
        miscompares++;
        $display("FAIL random_read n=%0d ra=%0d/%0d actual=%h/%h required=%h/%h",
                 n, raddr1, raddr2, rdata1, rdata2, e1, e2);
      end
      step();
      vectors++;
      if (wr_count !== 8'(model_cnt)) begin
        miscompares++; $display("FAIL random_count n=%0d actual=%0d required=%0d", n, wr_count, model_cnt);
      end
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_write_read();
    test_zero_write();
    test_bypass();
    test_saturation();
    test_sweep();
    test_mid_write_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
